issue_hazard_ctrl: RTL and testbench
====================================

Name: issue_hazard_ctrl

Overview:
- Scoreboard-based issue controller between the decode stage and EXE.
- Tracks destination registers of in-flight long-latency ops (loads, mul, div). Stalls decode on RAW/WAW hazards, on a busy divider, and at the outstanding-op limit.
- Kills the decode-stage instruction on a branch/exception flush.
- Consumes decode outputs: read enables, register addresses, write enable, write address.

Parameters:
- MAX_OUTSTANDING, 4, max long-latency ops in flight (1..15)
- FLUSH_CYCLES, 1, bubble cycles inserted after a flush (1..7)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid_i  in  1  decode holds a valid instruction
- id_reg1_read_i  in  1  source 1 read enable
- id_reg1_addr_i  in  5  source 1 register
- id_reg2_read_i  in  1  source 2 read enable
- id_reg2_addr_i  in  5  source 2 register
- id_wreg_i  in  1  instruction writes a register
- id_waddr_i  in  5  destination register
- id_long_i  in  1  long-latency op (load/mul/div)
- id_div_i  in  1  op uses the divider (implies id_long_i)
- wb_valid_i  in  1  long-latency op completes this cycle
- wb_waddr_i  in  5  register written by completing op
- div_done_i  in  1  divider finishes this cycle
- flush_i  in  1  branch/exception redirect
- stall_o  out  1  hold PC and IF/ID register
- issue_o  out  1  ID->EX latch takes a valid instruction
- bubble_o  out  1  ID->EX latch takes a NOP
- busy_vec_o  out  32  scoreboard busy bits; bit0 always 0
- pending_o  out  4  outstanding long-op count

Behaviour:
- Reset (rst=1 at clk edge): busy_vec_o=0, pending_o=0, div_busy=0, state=RUN, flush counter=0.
- Reset output values: stall_o=0, issue_o=0, bubble_o=1.
- Reset mid-operation discards all scoreboard state. Later wb_valid_i for pre-reset ops is ignored: clear of an already-clear bit, no count decrement below 0.
- Effective busy, eff_busy[r] = busy[r] & ~(wb_valid_i & wb_waddr_i==r). Same-cycle writeback resolves the hazard with no extra stall cycle.
- Hazard (combinational), OR of:
  - RAW: id_reg1_read_i & eff_busy[id_reg1_addr_i], or the same for reg2
  - WAW: id_wreg_i & eff_busy[id_waddr_i]
  - structural: id_div_i & div_busy & ~div_done_i
  - limit: id_long_i & (pending_o == MAX_OUTSTANDING) & ~wb_valid_i
  - Register 0 is never busy.
- States:
  - RUN: id_valid_i & hazard -> stall_o=1, bubble_o=1, issue_o=0; go to STALL. id_valid_i & ~hazard -> issue_o=1. ~id_valid_i -> bubble_o=1.
  - STALL: same outputs as RUN, evaluated each cycle; return to RUN in the first cycle the hazard clears, with issue_o=1 in that cycle.
  - FLUSH: stall_o=0, issue_o=0, bubble_o=1; counter runs FLUSH_CYCLES down to 0, then RUN.
- flush_i has priority in any state: that cycle issue_o=0, bubble_o=1, stall_o=0; next state FLUSH; counter loaded with FLUSH_CYCLES-1. flush_i during FLUSH reloads the counter.
- Issue of a long op with id_wreg_i & id_waddr_i!=0 sets busy[id_waddr_i] at the next edge.
- Issue of a long op increments pending; wb_valid_i decrements it; both in one cycle leave it unchanged.
- Same-cycle set and clear of one register: set wins.
- Issue with id_div_i sets div_busy; div_done_i clears it; set wins.
- Flush does not clear the scoreboard; in-flight ops still write back.
- Invariants (assert-checked): issue_o and bubble_o mutually exclusive, one of them 1 every cycle; stall_o=1 implies bubble_o=1.

Optional Feature:
- ISSUE_HAZARD_PERF_EN defined: adds outputs perf_stall_cnt_o (32, cycles with stall_o=1) and perf_flush_cnt_o (16, flush_i events). Both saturate at all-ones and reset to 0.
- Undefined: outputs and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - state encoding RUN=2'd0, STALL=2'd1, FLUSH=2'd2
  - scoreboard width constant REG_NUM=32
  - RegAddrBus width reused
- Sub-module issue_scoreboard: 32-bit busy vector with set/clear ports and the eff_busy bypass.
- FSM, counters and hazard logic stay in the top module.

Test Plan:
- Load-use: issue load to r5 (long); next instruction reads r5 -> stall_o=1 for 3 cycles; wb_valid_i with wb_waddr_i=5 in the 4th cycle -> issue_o=1 that same cycle, busy_vec_o[5]=0 after.
- r0 destination: long op writes r0 -> busy_vec_o stays 0; a following reader of r0 issues with no stall.
- Divider structural: div issued, second div follows -> stalled until div_done_i; issues in the div_done_i cycle; div_busy stays 1.
- Outstanding limit: 4 independent loads issue (pending_o=4); 5th load stalls; wb_valid_i -> 5th issues, pending_o stays 4.
- Flush during stall: RAW stall active, flush_i=1 -> bubble_o=1, stall_o=0, then FLUSH_CYCLES bubbles; busy bits preserved; later wb clears them.
- Reset mid-flight: busy_vec_o=0x0000_0120, pending_o=2, rst pulse -> all zero; late wb_valid_i for r8 -> pending_o stays 0.

Source files
------------

// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared types and constants for the issue hazard controller: FSM encoding,
// scoreboard width and the register-address decode helper.
package issue_hazard_ctrl_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // One-hot decode of a register address; r0 never decodes so it can never go busy.
  function automatic logic [REG_NUM-1:0] reg_decode(input logic en, input reg_addr_t addr);
    logic [REG_NUM-1:0] vec;
    vec = '0;
    if (en && (addr != 5'd0)) begin
      vec[addr] = 1'b1;
    end else begin
      vec = '0;
    end
    return vec;
  endfunction

endpackage

// File: rtl/issue_hazard_ctrl_chk.sv
// Protocol checker for issue_hazard_ctrl outputs: issue/bubble one-hot and
// stall implying bubble.
module issue_hazard_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic stall_o,
  input logic issue_o,
  input logic bubble_o
);

  a_issue_bubble_onehot: assert property (@(posedge clk) disable iff (rst) (issue_o ^ bubble_o));
  a_stall_bubble:        assert property (@(posedge clk) disable iff (rst) (stall_o |-> bubble_o));

endmodule

// File: rtl/issue_hazard_ctrl_scoreboard.sv
// Busy-bit scoreboard for in-flight long-latency destinations, with a
// writeback bypass so a same-cycle completion hides its busy bit.
module issue_scoreboard
  import issue_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [4:0]  set_addr,
  input  logic        clr_en,
  input  logic [4:0]  clr_addr,
  output logic [31:0] busy_vec,
  output logic [31:0] eff_busy
);

  logic [REG_NUM-1:0] busy_r;
  logic [REG_NUM-1:0] set_mask_s;
  logic [REG_NUM-1:0] clr_mask_s;

  // Set/clear masks and bypassed busy view.
  always_comb begin
    set_mask_s = reg_decode(set_en, set_addr);
    clr_mask_s = reg_decode(clr_en, clr_addr);
    eff_busy   = busy_r & ~clr_mask_s;
  end

  // Busy register; a set on the same register as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  assign busy_vec = busy_r;

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Scoreboard-based decode->EXE issue controller with flush handling.
// Optional perf counters are enabled by defining ISSUE_HAZARD_PERF_EN.
module issue_hazard_ctrl
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int FLUSH_CYCLES    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic        id_reg1_read_i,
  input  logic [4:0]  id_reg1_addr_i,
  input  logic        id_reg2_read_i,
  input  logic [4:0]  id_reg2_addr_i,
  input  logic        id_wreg_i,
  input  logic [4:0]  id_waddr_i,
  input  logic        id_long_i,
  input  logic        id_div_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic        div_done_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        issue_o,
  output logic        bubble_o,
  output logic [31:0] busy_vec_o,
  output logic [3:0]  pending_o
`ifdef ISSUE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [15:0] perf_flush_cnt_o
`endif
);

  state_e             state_r, state_nxt_s;
  logic [2:0]         flush_cnt_r, flush_cnt_nxt_s;
  logic [3:0]         pending_r;
  logic               div_busy_r;
  logic [REG_NUM-1:0] eff_busy_s;
  logic               hazard_s;
  logic               inc_s, dec_s;

  issue_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_o & id_long_i & id_wreg_i),
    .set_addr (id_waddr_i),
    .clr_en   (wb_valid_i),
    .clr_addr (wb_waddr_i),
    .busy_vec (busy_vec_o),
    .eff_busy (eff_busy_s)
  );

  // Hazard detection against the bypassed scoreboard.
  always_comb begin
    hazard_s = (id_reg1_read_i & eff_busy_s[id_reg1_addr_i])
             | (id_reg2_read_i & eff_busy_s[id_reg2_addr_i])
             | (id_wreg_i      & eff_busy_s[id_waddr_i])
             | (id_div_i & div_busy_r & ~div_done_i)
             | (id_long_i & (pending_r == 4'(MAX_OUTSTANDING)) & ~wb_valid_i);
  end

  // FSM state and flush counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      flush_cnt_r <= 3'd0;
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
    end
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    if (flush_i) begin
      state_nxt_s     = ST_FLUSH;
      flush_cnt_nxt_s = 3'(FLUSH_CYCLES - 1);
    end else begin
      case (state_r)
        ST_RUN, ST_STALL: state_nxt_s = (id_valid_i & hazard_s) ? ST_STALL : ST_RUN;
        ST_FLUSH: begin
          if (flush_cnt_r == 3'd0) begin
            state_nxt_s = ST_RUN;
          end else begin
            flush_cnt_nxt_s = flush_cnt_r - 3'd1;
          end
        end
        default: state_nxt_s = ST_RUN;
      endcase
    end
  end

  // Output decode; anything that does not issue becomes a bubble.
  always_comb begin
    stall_o  = 1'b0;
    issue_o  = 1'b0;
    bubble_o = 1'b1;
    if (rst || flush_i) begin
      bubble_o = 1'b1;
    end else begin
      case (state_r)
        ST_RUN, ST_STALL: begin
          if (id_valid_i && hazard_s) begin
            stall_o = 1'b1;
          end else if (id_valid_i) begin
            issue_o  = 1'b1;
            bubble_o = 1'b0;
          end else begin
            bubble_o = 1'b1;
          end
        end
        ST_FLUSH: bubble_o = 1'b1;
        default:  bubble_o = 1'b1;
      endcase
    end
  end

  // Decrement is suppressed at zero so late writebacks after reset are harmless.
  always_comb begin
    inc_s = issue_o & id_long_i;
    dec_s = wb_valid_i & (pending_r != 4'd0);
  end

  // Outstanding-op count and divider busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r  <= 4'd0;
      div_busy_r <= 1'b0;
    end else begin
      case ({inc_s, dec_s})
        2'b10:   pending_r <= pending_r + 4'd1;
        2'b01:   pending_r <= pending_r - 4'd1;
        default: pending_r <= pending_r;
      endcase
      if (issue_o && id_div_i) begin
        div_busy_r <= 1'b1;
      end else if (div_done_i) begin
        div_busy_r <= 1'b0;
      end else begin
        div_busy_r <= div_busy_r;
      end
    end
  end

  assign pending_o = pending_r;

`ifdef ISSUE_HAZARD_PERF_EN
  logic [31:0] perf_stall_r;
  logic [15:0] perf_flush_r;

  // Saturating stall-cycle and flush-event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 16'd0;
    end else begin
      if (stall_o && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      if (flush_i && (perf_flush_r != 16'hFFFF)) begin
        perf_flush_r <= perf_flush_r + 16'd1;
      end
    end
  end

  assign perf_stall_cnt_o = perf_stall_r;
  assign perf_flush_cnt_o = perf_flush_r;
`endif

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed scoreboard bench for issue_hazard_ctrl: expected stall/issue/bubble
// triples are queued with each stimulus cycle and compared mid-cycle.
module tb_issue_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, id_reg1_read_i, id_reg2_read_i, id_wreg_i, id_long_i, id_div_i;
  logic [4:0]  id_reg1_addr_i, id_reg2_addr_i, id_waddr_i, wb_waddr_i;
  logic        wb_valid_i, div_done_i, flush_i;
  logic        stall_o, issue_o, bubble_o;
  logic [31:0] busy_vec_o;
  logic [3:0]  pending_o;
`ifdef ISSUE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt_o;
  logic [15:0] perf_flush_cnt_o;
`endif

  typedef struct {
    string tag;
    logic  stall;
    logic  issue;
    logic  bubble;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  issue_hazard_ctrl #(.MAX_OUTSTANDING(4), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
    .id_wreg_i(id_wreg_i), .id_waddr_i(id_waddr_i), .id_long_i(id_long_i), .id_div_i(id_div_i),
    .wb_valid_i(wb_valid_i), .wb_waddr_i(wb_waddr_i), .div_done_i(div_done_i), .flush_i(flush_i),
    .stall_o(stall_o), .issue_o(issue_o), .bubble_o(bubble_o),
    .busy_vec_o(busy_vec_o), .pending_o(pending_o)
`ifdef ISSUE_HAZARD_PERF_EN
    , .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
  );

  issue_hazard_ctrl_chk u_chk (
    .clk(clk), .rst(rst), .stall_o(stall_o), .issue_o(issue_o), .bubble_o(bubble_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid_i = 1'b0; id_reg1_read_i = 1'b0; id_reg1_addr_i = 5'd0;
    id_reg2_read_i = 1'b0; id_reg2_addr_i = 5'd0; id_wreg_i = 1'b0; id_waddr_i = 5'd0;
    id_long_i = 1'b0; id_div_i = 1'b0;
    wb_valid_i = 1'b0; wb_waddr_i = 5'd0; div_done_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic instr(input logic r1rd, input logic [4:0] r1, input logic wr,
                       input logic [4:0] wa, input logic lg, input logic dv);
    id_valid_i = 1'b1; id_reg1_read_i = r1rd; id_reg1_addr_i = r1;
    id_reg2_read_i = 1'b0; id_reg2_addr_i = 5'd0;
    id_wreg_i = wr; id_waddr_i = wa; id_long_i = lg; id_div_i = dv;
  endtask

  task automatic wb(input logic [4:0] a);
    wb_valid_i = 1'b1; wb_waddr_i = a;
  endtask

  // Queue the expected triple, sample mid-cycle, then advance to the next negedge.
  task automatic cycle(input string tag, input logic s, input logic i, input logic b);
    exp_t e;
    exp_q.push_back('{tag, s, i, b});
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({e.tag, ".stall"},  {31'd0, stall_o},  {31'd0, e.stall});
      check_val({e.tag, ".issue"},  {31'd0, issue_o},  {31'd0, e.issue});
      check_val({e.tag, ".bubble"}, {31'd0, bubble_o}, {31'd0, e.bubble});
    end
    @(negedge clk);
  endtask

  task automatic state_chk(input string tag, input logic [31:0] busy, input logic [3:0] pend);
    check_val({tag, ".busy"},    busy_vec_o, busy);
    check_val({tag, ".pending"}, {28'd0, pending_o}, {28'd0, pend});
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    cycle("reset_out", 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    state_chk("reset", 32'h0, 4'd0);
    cycle("idle", 1'b0, 1'b0, 1'b1);

    // Load-use on r5
    instr(1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    cycle("lu_load", 1'b0, 1'b1, 1'b0);
    state_chk("lu_after_load", 32'h0000_0020, 4'd1);
    instr(1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle("lu_stall", 1'b1, 1'b0, 1'b1);
    wb(5'd5);
    cycle("lu_wb_issue", 1'b0, 1'b1, 1'b0);
    idle();
    state_chk("lu_done", 32'h0, 4'd0);

    // r0 destination never goes busy
    instr(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    cycle("r0_load", 1'b0, 1'b1, 1'b0);
    state_chk("r0_after", 32'h0, 4'd1);
    instr(1'b1, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0);
    cycle("r0_reader", 1'b0, 1'b1, 1'b0);
    idle(); wb(5'd0);
    cycle("r0_drain", 1'b0, 1'b0, 1'b1);
    idle();
    state_chk("r0_done", 32'h0, 4'd0);

    // Divider structural hazard
    instr(1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b1);
    cycle("div1", 1'b0, 1'b1, 1'b0);
    state_chk("div1_after", 32'h0000_0080, 4'd1);
    instr(1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) cycle("div2_stall", 1'b1, 1'b0, 1'b1);
    div_done_i = 1'b1;
    cycle("div2_issue", 1'b0, 1'b1, 1'b0);
    div_done_i = 1'b0;
    instr(1'b0, 5'd0, 1'b1, 5'd11, 1'b1, 1'b1);
    cycle("div3_stall", 1'b1, 1'b0, 1'b1);
    idle(); div_done_i = 1'b1;
    cycle("div_done_idle", 1'b0, 1'b0, 1'b1);
    idle(); wb(5'd7);
    cycle("div_wb7", 1'b0, 1'b0, 1'b1);
    idle(); wb(5'd9);
    cycle("div_wb9", 1'b0, 1'b0, 1'b1);
    idle();
    state_chk("div_done", 32'h0, 4'd0);

    // Outstanding limit
    for (int k = 1; k <= 4; k++) begin
      instr(1'b0, 5'd0, 1'b1, 5'(k), 1'b1, 1'b0);
      cycle("lim_load", 1'b0, 1'b1, 1'b0);
    end
    state_chk("lim_full", 32'h0000_001E, 4'd4);
    instr(1'b0, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
    cycle("lim_stall", 1'b1, 1'b0, 1'b1);
    wb(5'd1);
    cycle("lim_wb_issue", 1'b0, 1'b1, 1'b0);
    idle();
    state_chk("lim_after", 32'h0000_041C, 4'd4);
    wb(5'd2);  cycle("lim_d2", 1'b0, 1'b0, 1'b1);
    wb(5'd3);  cycle("lim_d3", 1'b0, 1'b0, 1'b1);
    wb(5'd4);  cycle("lim_d4", 1'b0, 1'b0, 1'b1);
    wb(5'd10); cycle("lim_d10", 1'b0, 1'b0, 1'b1);
    idle();
    state_chk("lim_done", 32'h0, 4'd0);

    // Flush during a RAW stall
    instr(1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    cycle("fl_load", 1'b0, 1'b1, 1'b0);
    instr(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle("fl_stall", 1'b1, 1'b0, 1'b1);
    flush_i = 1'b1;
    cycle("fl_flush", 1'b0, 1'b0, 1'b1);
    flush_i = 1'b0;
    instr(1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle("fl_bubble", 1'b0, 1'b0, 1'b1);
    state_chk("fl_kept", 32'h0000_0020, 4'd1);
    cycle("fl_run_issue", 1'b0, 1'b1, 1'b0);
    idle(); wb(5'd5);
    cycle("fl_wb", 1'b0, 1'b0, 1'b1);
    idle();
    state_chk("fl_done", 32'h0, 4'd0);

    // WAW stall, then same-cycle set/clear of r3
    instr(1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
    cycle("waw_load", 1'b0, 1'b1, 1'b0);
    instr(1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
    cycle("waw_stall", 1'b1, 1'b0, 1'b1);
    instr(1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0); wb(5'd3);
    cycle("setclr_issue", 1'b0, 1'b1, 1'b0);
    idle();
    state_chk("setclr", 32'h0000_0008, 4'd1);
    wb(5'd3);
    cycle("setclr_wb", 1'b0, 1'b0, 1'b1);
    idle();
    state_chk("setclr_done", 32'h0, 4'd0);

    // Reset mid-flight, then late writeback
    instr(1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    cycle("rm_l5", 1'b0, 1'b1, 1'b0);
    instr(1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    cycle("rm_l8", 1'b0, 1'b1, 1'b0);
    idle();
    state_chk("rm_before", 32'h0000_0120, 4'd2);
    rst = 1'b1;
    cycle("rm_rst", 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    state_chk("rm_after", 32'h0, 4'd0);
    wb(5'd8);
    cycle("rm_late_wb", 1'b0, 1'b0, 1'b1);
    idle();
    state_chk("rm_late", 32'h0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
